// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program sequencer.
package prog_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_WAITMEM = 3'd2,
      ST_LOAD    = 3'd3,
      ST_START   = 3'd4,
      ST_EXEC    = 3'd5,
      ST_HALT    = 3'd6
   } state_t;

   localparam logic [2:0] HALT_OPCODE = 3'b111;
   localparam int         OPCODE_MSB  = 15;
   localparam int         OPCODE_LSB  = 13;

   // True when the instruction word carries the HALT opcode in its top field.
   function automatic logic is_halt(input logic [15:0] word);
      return word[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;
   endfunction

endpackage

// File: rtl/prog_seq_pc.sv
// Program counter: PC_W-bit register, synchronous reset to RESET_PC, increments
// (wrapping modulo 2^PC_W) when inc is high.
module prog_seq_pc #(
   parameter int unsigned     PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            inc,
   output logic [PC_W-1:0] pc
);

   // PC register; natural overflow of the adder gives the wrap to zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= RESET_PC;
      end else if (inc) begin
         pc <= pc + PC_W'(1);
      end
   end

endmodule

// File: rtl/prog_seq.sv
// Program sequencer: fetches one instruction per step from a synchronous
// program RAM, hands it to the cpu and waits for the cpu to finish.
// Build option: PROG_SEQ_STEP_EN selects single-step mode (one instruction per
// run request); left undefined the sequencer free-runs until HALT.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | waiting for run while the cpu reports done
//   FETCH    | mem_rd strobe, latency counter cleared
//   WAITMEM  | counting RAM latency, capture word into ir_data on last cycle
//   LOAD     | ir_load strobe, decode HALT opcode
//   START    | start strobe to the cpu
//   EXEC     | cpu running; first cycle ignores cpu_w, then wait for cpu_w
//   HALT     | halted, only reset leaves
module prog_seq
   import prog_seq_pkg::*;
#(
   parameter int unsigned PC_W     = 8,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned MEM_LAT  = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   output logic            mem_rd,
   output logic [PC_W-1:0] mem_addr,
   input  logic [15:0]     mem_rdata,
   output logic            ir_load,
   output logic [15:0]     ir_data,
   output logic            start,
   input  logic            cpu_w,
   output logic [PC_W-1:0] pc,
   output logic            halted
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);

   state_t             state;
   state_t             state_nx;
   logic [CNT_W-1:0]   lat_cnt;
   logic               lat_done;
   logic               exec_armed;
   logic               pc_inc;

   prog_seq_pc #(
      .PC_W     (PC_W),
      .RESET_PC (PC_W'(RESET_PC))
   ) u_pc (
      .clk   (clk),
      .reset (reset),
      .inc   (pc_inc),
      .pc    (pc)
   );

   assign mem_addr = pc;
   assign lat_done = (lat_cnt == CNT_W'(MEM_LAT - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode and PC increment request.
   always_comb begin
      state_nx = state;
      pc_inc   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (run && cpu_w) state_nx = ST_FETCH;
         end
         ST_FETCH: begin
            state_nx = ST_WAITMEM;
         end
         ST_WAITMEM: begin
            if (lat_done) state_nx = ST_LOAD;
         end
         ST_LOAD: begin
            if (is_halt(ir_data)) state_nx = ST_HALT;
            else                  state_nx = ST_START;
         end
         ST_START: begin
            state_nx = ST_EXEC;
         end
         ST_EXEC: begin
            // cpu_w is still high on the first EXEC cycle, before the cpu reacts to start.
            if (exec_armed && cpu_w) begin
               pc_inc = 1'b1;
`ifdef PROG_SEQ_STEP_EN
               state_nx = ST_IDLE;
`else
               state_nx = ST_FETCH;
`endif
            end
         end
         ST_HALT: begin
            state_nx = ST_HALT;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Latency counter, instruction capture and registered strobes aligned with their states.
   always_ff @(posedge clk) begin
      if (reset) begin
         lat_cnt    <= '0;
         exec_armed <= 1'b0;
         ir_data    <= '0;
         mem_rd     <= 1'b0;
         ir_load    <= 1'b0;
         start      <= 1'b0;
         halted     <= 1'b0;
      end else begin
         if (state == ST_FETCH) begin
            lat_cnt <= '0;
         end else if (state == ST_WAITMEM && !lat_done) begin
            lat_cnt <= lat_cnt + CNT_W'(1);
         end
         exec_armed <= (state == ST_EXEC);
         if (state == ST_WAITMEM && lat_done) begin
            ir_data <= mem_rdata;
         end
         mem_rd  <= (state_nx == ST_FETCH);
         ir_load <= (state_nx == ST_LOAD);
         start   <= (state_nx == ST_START);
         halted  <= (state_nx == ST_HALT);
      end
   end

endmodule

// File: tb/tb_prog_seq.sv
// Bench for prog_seq: three instances (default, RESET_PC=FF, MEM_LAT=3), each with
// its own program RAM model and a cpu model that stays busy 3 cycles after start.
module tb_prog_seq;

   localparam int N        = 3;
   localparam int EXEC_LEN = 3;

   logic        clk = 1'b0;
   logic        reset_v   [N];
   logic        run_v     [N];
   logic        hold_v    [N];
   logic        clr_v     [N];
   logic        cpu_w_v   [N];
   logic        mem_rd_v  [N];
   logic [7:0]  mem_addr_v[N];
   logic [15:0] mem_rdata_v[N];
   logic        ir_load_v [N];
   logic [15:0] ir_data_v [N];
   logic        start_v   [N];
   logic [7:0]  pc_v      [N];
   logic        halted_v  [N];

   logic [15:0] ram [N][256];

   int          cyc = 0;
   int          rd_cnt  [N];
   int          ld_cnt  [N];
   int          st_cnt  [N];
   int          ovl_cnt [N];
   int          first_rd[N];
   int          last_rd [N];
   int          first_ld[N];
   logic [15:0] ld_first[N];
   logic [15:0] ld_last [N];

   int          tests_run = 0;
   int          tests_failed = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int          LAT = (g == 2) ? 3 : 1;
      localparam int unsigned RPC = (g == 1) ? 255 : 0;

      logic [15:0] pipe [LAT];
      int          busy_cnt;

      prog_seq #(
         .PC_W     (8),
         .RESET_PC (RPC),
         .MEM_LAT  (LAT)
      ) u_dut (
         .clk       (clk),
         .reset     (reset_v[g]),
         .run       (run_v[g]),
         .mem_rd    (mem_rd_v[g]),
         .mem_addr  (mem_addr_v[g]),
         .mem_rdata (mem_rdata_v[g]),
         .ir_load   (ir_load_v[g]),
         .ir_data   (ir_data_v[g]),
         .start     (start_v[g]),
         .cpu_w     (cpu_w_v[g]),
         .pc        (pc_v[g]),
         .halted    (halted_v[g])
      );

      // Program RAM: data appears LAT cycles after the read strobe, garbage otherwise.
      always @(posedge clk) begin
         pipe[0] <= mem_rd_v[g] ? ram[g][mem_addr_v[g]] : 16'hDEAD;
         for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign mem_rdata_v[g] = pipe[LAT-1];

      // cpu: w drops the cycle after start and returns after EXEC_LEN cycles.
      always @(posedge clk) begin
         if (reset_v[g])      busy_cnt <= 0;
         else if (start_v[g]) busy_cnt <= EXEC_LEN;
         else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      end
      assign cpu_w_v[g] = (busy_cnt == 0) && !hold_v[g];
   end

   // Strobe monitor on the falling edge.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      for (int g = 0; g < N; g++) begin
         if (clr_v[g]) begin
            rd_cnt[g]   <= 0;
            ld_cnt[g]   <= 0;
            st_cnt[g]   <= 0;
            ovl_cnt[g]  <= 0;
            first_rd[g] <= -1;
            last_rd[g]  <= -1;
            first_ld[g] <= -1;
            ld_first[g] <= 16'h0000;
            ld_last[g]  <= 16'h0000;
         end else begin
            if (mem_rd_v[g]) begin
               rd_cnt[g]  <= rd_cnt[g] + 1;
               last_rd[g] <= cyc;
               if (first_rd[g] < 0) first_rd[g] <= cyc;
            end
            if (ir_load_v[g]) begin
               ld_cnt[g]  <= ld_cnt[g] + 1;
               ld_last[g] <= ir_data_v[g];
               if (first_ld[g] < 0) begin
                  first_ld[g] <= cyc;
                  ld_first[g] <= ir_data_v[g];
               end
            end
            if (start_v[g]) st_cnt[g] <= st_cnt[g] + 1;
            if ((int'(mem_rd_v[g]) + int'(ir_load_v[g]) + int'(start_v[g])) > 1)
               ovl_cnt[g] <= ovl_cnt[g] + 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon(input int g);
      clr_v[g] = 1'b1;
      @(negedge clk);
      #1;
      clr_v[g] = 1'b0;
   endtask

   task automatic apply_reset(input int g);
      reset_v[g] = 1'b1;
      run_v[g]   = 1'b0;
      tick();
      tick();
      reset_v[g] = 1'b0;
      clear_mon(g);
      tick();
   endtask

   task automatic pulse_run(input int g);
      run_v[g] = 1'b1;
      tick();
      run_v[g] = 1'b0;
   endtask

   // Runs until halted; one extra run pulse when pc reaches rp_pc (needed in single-step builds).
   task automatic run_to_halt(input int g, input logic [7:0] rp_pc, output logic ok);
      logic pulsed;
      pulsed = 1'b0;
      ok     = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (halted_v[g]) begin
            ok = 1'b1;
            break;
         end
         if (!pulsed && pc_v[g] == rp_pc) begin
            pulsed = 1'b1;
            pulse_run(g);
         end
      end
   endtask

   task automatic test_reset();
      reset_v[0] = 1'b1;
      tick();
      tick();
      tests_run++; if (mem_rd_v[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd_v[0]); end
      tests_run++; if (ir_load_v[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_ir_load: got %b expected 0", ir_load_v[0]); end
      tests_run++; if (start_v[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_start: got %b expected 0", start_v[0]); end
      tests_run++; if (halted_v[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_halted: got %b expected 0", halted_v[0]); end
      tests_run++; if (pc_v[0] !== 8'h00) begin tests_failed++; $display("FAIL reset_pc: got %h expected 00", pc_v[0]); end
      tests_run++; if (ir_data_v[0] !== 16'h0000) begin tests_failed++; $display("FAIL reset_ir_data: got %h expected 0000", ir_data_v[0]); end
      tests_run++; if (pc_v[1] !== 8'hFF) begin tests_failed++; $display("FAIL reset_pc_ff: got %h expected ff", pc_v[1]); end
      reset_v[0] = 1'b0;
      clear_mon(0);
   endtask

   task automatic test_run_gate();
      hold_v[0] = 1'b1;
      run_v[0]  = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      tests_run++; if (rd_cnt[0] !== 0) begin tests_failed++; $display("FAIL gate_no_fetch: got %0d reads expected 0", rd_cnt[0]); end
      hold_v[0] = 1'b0;
      tick();
      tests_run++; if (mem_rd_v[0] !== 1'b1) begin tests_failed++; $display("FAIL gate_mem_rd: got %b expected 1", mem_rd_v[0]); end
      tests_run++; if (mem_addr_v[0] !== 8'h00) begin tests_failed++; $display("FAIL gate_mem_addr: got %h expected 00", mem_addr_v[0]); end
      run_v[0] = 1'b0;
      apply_reset(0);
   endtask

   task automatic test_halt();
      logic ok;
      apply_reset(0);
      pulse_run(0);
      run_to_halt(0, 8'h01, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL halt_timeout: got %b expected 1", ok); end
      tests_run++; if (halted_v[0] !== 1'b1) begin tests_failed++; $display("FAIL halt_flag: got %b expected 1", halted_v[0]); end
      tests_run++; if (pc_v[0] !== 8'h01) begin tests_failed++; $display("FAIL halt_pc: got %h expected 01", pc_v[0]); end
      tests_run++; if (st_cnt[0] !== 1) begin tests_failed++; $display("FAIL halt_starts: got %0d expected 1", st_cnt[0]); end
      tests_run++; if (ld_cnt[0] !== 2) begin tests_failed++; $display("FAIL halt_loads: got %0d expected 2", ld_cnt[0]); end
      tests_run++; if (ld_first[0] !== 16'hD005) begin tests_failed++; $display("FAIL halt_ir_first: got %h expected d005", ld_first[0]); end
      tests_run++; if (ld_last[0] !== 16'hE000) begin tests_failed++; $display("FAIL halt_ir_last: got %h expected e000", ld_last[0]); end
      tests_run++; if (first_ld[0] - first_rd[0] !== 2) begin tests_failed++; $display("FAIL halt_rd_to_load: got %0d expected 2", first_ld[0] - first_rd[0]); end
`ifndef PROG_SEQ_STEP_EN
      tests_run++; if (last_rd[0] - first_rd[0] !== 8) begin tests_failed++; $display("FAIL step_latency: got %0d expected 8", last_rd[0] - first_rd[0]); end
`endif
      pulse_run(0);
      for (int i = 0; i < 20; i++) tick();
      tests_run++; if (pc_v[0] !== 8'h01) begin tests_failed++; $display("FAIL halt_hold_pc: got %h expected 01", pc_v[0]); end
      tests_run++; if (st_cnt[0] !== 1) begin tests_failed++; $display("FAIL halt_no_restart: got %0d expected 1", st_cnt[0]); end
      tests_run++; if (rd_cnt[0] !== 2) begin tests_failed++; $display("FAIL halt_no_fetch: got %0d expected 2", rd_cnt[0]); end
      tests_run++; if (halted_v[0] !== 1'b1) begin tests_failed++; $display("FAIL halt_stays: got %b expected 1", halted_v[0]); end
   endtask

   task automatic test_reset_exec();
      logic seen;
      apply_reset(0);
      pulse_run(0);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick();
         if (start_v[0]) seen = 1'b1;
      end
      tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL rexec_start_seen: got %b expected 1", seen); end
      tick();
      tick();
      reset_v[0] = 1'b1;
      tick();
      tests_run++; if (start_v[0] !== 1'b0) begin tests_failed++; $display("FAIL rexec_start: got %b expected 0", start_v[0]); end
      tests_run++; if (ir_load_v[0] !== 1'b0) begin tests_failed++; $display("FAIL rexec_ir_load: got %b expected 0", ir_load_v[0]); end
      tests_run++; if (halted_v[0] !== 1'b0) begin tests_failed++; $display("FAIL rexec_halted: got %b expected 0", halted_v[0]); end
      tests_run++; if (pc_v[0] !== 8'h00) begin tests_failed++; $display("FAIL rexec_pc: got %h expected 00", pc_v[0]); end
      reset_v[0] = 1'b0;
      clear_mon(0);
      for (int i = 0; i < 10; i++) tick();
      tests_run++; if (rd_cnt[0] !== 0) begin tests_failed++; $display("FAIL rexec_idle: got %0d reads expected 0", rd_cnt[0]); end
      pulse_run(0);
      tests_run++; if (mem_rd_v[0] !== 1'b1) begin tests_failed++; $display("FAIL rexec_refetch: got %b expected 1", mem_rd_v[0]); end
      tests_run++; if (mem_addr_v[0] !== 8'h00) begin tests_failed++; $display("FAIL rexec_refetch_addr: got %h expected 00", mem_addr_v[0]); end
   endtask

   task automatic test_wrap();
      logic ok;
      ram[1][255] = 16'h1234;
      ram[1][0]   = 16'hE000;
      apply_reset(1);
      tests_run++; if (pc_v[1] !== 8'hFF) begin tests_failed++; $display("FAIL wrap_reset_pc: got %h expected ff", pc_v[1]); end
      pulse_run(1);
      tests_run++; if (mem_addr_v[1] !== 8'hFF) begin tests_failed++; $display("FAIL wrap_first_addr: got %h expected ff", mem_addr_v[1]); end
      run_to_halt(1, 8'h00, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL wrap_timeout: got %b expected 1", ok); end
      tests_run++; if (pc_v[1] !== 8'h00) begin tests_failed++; $display("FAIL wrap_pc: got %h expected 00", pc_v[1]); end
      tests_run++; if (st_cnt[1] !== 1) begin tests_failed++; $display("FAIL wrap_starts: got %0d expected 1", st_cnt[1]); end
      tests_run++; if (ld_last[1] !== 16'hE000) begin tests_failed++; $display("FAIL wrap_ir: got %h expected e000", ld_last[1]); end
   endtask

   task automatic test_latency();
      logic ok;
      ram[2][0] = 16'h2ABC;
      ram[2][1] = 16'hE000;
      apply_reset(2);
      pulse_run(2);
      run_to_halt(2, 8'h01, ok);
      tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL lat_timeout: got %b expected 1", ok); end
      tests_run++; if (first_ld[2] - first_rd[2] !== 4) begin tests_failed++; $display("FAIL lat_rd_to_load: got %0d expected 4", first_ld[2] - first_rd[2]); end
      tests_run++; if (ld_first[2] !== 16'h2ABC) begin tests_failed++; $display("FAIL lat_ir_first: got %h expected 2abc", ld_first[2]); end
      tests_run++; if (ld_last[2] !== 16'hE000) begin tests_failed++; $display("FAIL lat_ir_last: got %h expected e000", ld_last[2]); end
      tests_run++; if (pc_v[2] !== 8'h01) begin tests_failed++; $display("FAIL lat_pc: got %h expected 01", pc_v[2]); end
   endtask

`ifdef PROG_SEQ_STEP_EN
   task automatic test_step();
      ram[0][1] = 16'h1111;
      apply_reset(0);
      pulse_run(0);
      for (int i = 0; i < 40; i++) tick();
      tests_run++; if (st_cnt[0] !== 1) begin tests_failed++; $display("FAIL step_starts: got %0d expected 1", st_cnt[0]); end
      tests_run++; if (pc_v[0] !== 8'h01) begin tests_failed++; $display("FAIL step_pc: got %h expected 01", pc_v[0]); end
      tests_run++; if (rd_cnt[0] !== 1) begin tests_failed++; $display("FAIL step_reads: got %0d expected 1", rd_cnt[0]); end
      tests_run++; if (halted_v[0] !== 1'b0) begin tests_failed++; $display("FAIL step_halted: got %b expected 0", halted_v[0]); end
      pulse_run(0);
      tests_run++; if (mem_addr_v[0] !== 8'h01) begin tests_failed++; $display("FAIL step_next_addr: got %h expected 01", mem_addr_v[0]); end
      tests_run++; if (mem_rd_v[0] !== 1'b1) begin tests_failed++; $display("FAIL step_next_rd: got %b expected 1", mem_rd_v[0]); end
      apply_reset(0);
   endtask
`else
   task automatic test_free();
      logic reached;
      ram[0][1] = 16'h1111;
      apply_reset(0);
      pulse_run(0);
      reached = 1'b0;
      for (int i = 0; i < 60 && !reached; i++) begin
         tick();
         if (pc_v[0] == 8'h02) reached = 1'b1;
      end
      tests_run++; if (reached !== 1'b1) begin tests_failed++; $display("FAIL free_reach_pc2: got %b expected 1", reached); end
      tests_run++; if (st_cnt[0] !== 2) begin tests_failed++; $display("FAIL free_starts: got %0d expected 2", st_cnt[0]); end
      tests_run++; if (mem_rd_v[0] !== 1'b1) begin tests_failed++; $display("FAIL free_refetch: got %b expected 1", mem_rd_v[0]); end
      apply_reset(0);
   endtask
`endif

   task automatic test_exclusive();
      for (int g = 0; g < N; g++) begin
         tests_run++; if (ovl_cnt[g] !== 0) begin tests_failed++; $display("FAIL strobe_overlap_%0d: got %0d expected 0", g, ovl_cnt[g]); end
      end
   endtask

   initial begin
      for (int g = 0; g < N; g++) begin
         reset_v[g] = 1'b1;
         run_v[g]   = 1'b0;
         hold_v[g]  = 1'b0;
         clr_v[g]   = 1'b1;
         for (int a = 0; a < 256; a++) ram[g][a] = 16'h0000;
      end
      ram[0][0] = 16'hD005;
      ram[0][1] = 16'hE000;
      tick();
      tick();
      for (int g = 1; g < N; g++) reset_v[g] = 1'b0;
      for (int g = 0; g < N; g++) clr_v[g] = 1'b0;

      test_reset();
      test_run_gate();
      test_halt();
      test_reset_exec();
      test_wrap();
      test_latency();
`ifdef PROG_SEQ_STEP_EN
      test_step();
`else
      test_free();
`endif
      test_exclusive();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
